// File: rtl/prison_game_if.sv
// Game-control / box-port bundle for the prisoners-and-boxes round sequencer.
// master = the sequencer, slave = game control plus box storage.
interface prison_game_if #(
   parameter int IDX_W = 3
);
   logic             start;
   logic             box_rd;
   logic [IDX_W-1:0] box_sel;
   logic [IDX_W-1:0] box_content;
   logic             busy;
   logic             done;
   logic             win;
   logic [IDX_W-1:0] fail_prisoner;
   logic [IDX_W:0]   fail_count;
   logic [15:0]      total_opens;

   modport master (
      input  start, box_content,
      output box_rd, box_sel, busy, done, win, fail_prisoner, fail_count, total_opens
   );

   modport slave (
      output start, box_content,
      input  box_rd, box_sel, busy, done, win, fail_prisoner, fail_count, total_opens
   );
endinterface

// File: rtl/prison_game_controller.sv
// Runs one prisoners-and-boxes round with the cycle-following strategy.
// Build option PRISON_EARLY_ABORT_EN: the first failing prisoner ends the round.
module prison_game_controller #(
   parameter int N_PRISONERS = 8,
   parameter int IDX_W       = 3,
   parameter int MAX_OPENS   = 4
) (
   input  logic          clk,
   input  logic          rst,
   prison_game_if.master game_io
);

   localparam int OPN_W = $clog2(MAX_OPENS + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_OPEN,
      S_EVAL,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] p_q, p_d;
   logic [IDX_W-1:0] box_q, box_d;
   logic [OPN_W-1:0] opens_q, opens_d;
   logic             win_q, win_d;
   logic [IDX_W-1:0] fail_prisoner_q, fail_prisoner_d;
   logic [IDX_W:0]   fail_count_q, fail_count_d;
   logic [15:0]      total_opens_q, total_opens_d;

   logic slip_hit;
   logic slip_bad;
   logic p_last;

   assign slip_hit = (game_io.box_content == p_q);
   assign slip_bad = (int'(game_io.box_content) >= N_PRISONERS);
   assign p_last   = (int'(p_q) == N_PRISONERS - 1);

   // NOTE: every _d gets its hold value first, so no path through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d         = state_q;
      p_d             = p_q;
      box_d           = box_q;
      opens_d         = opens_q;
      win_d           = win_q;
      fail_prisoner_d = fail_prisoner_q;
      fail_count_d    = fail_count_q;
      total_opens_d   = total_opens_q;

      unique case (state_q)
         S_IDLE: begin
            if (game_io.start) begin
               win_d           = 1'b0;
               fail_prisoner_d = '0;
               fail_count_d    = '0;
               total_opens_d   = '0;
               p_d             = '0;
               box_d           = '0;
               opens_d         = '0;
               state_d         = S_OPEN;
            end
         end

         S_OPEN: begin
            opens_d = opens_q + 1'b1;
            if (total_opens_q != 16'hFFFF) begin
               total_opens_d = total_opens_q + 16'd1;
            end
            state_d = S_EVAL;
         end

         S_EVAL: begin
            if (slip_hit) begin
               if (p_last) begin
                  win_d   = (fail_count_q == '0);
                  state_d = S_DONE;
               end else begin
                  p_d     = p_q + 1'b1;
                  box_d   = p_q + 1'b1;
                  opens_d = '0;
                  state_d = S_OPEN;
               end
            end else if (!slip_bad && (int'(opens_q) < MAX_OPENS)) begin
               box_d   = game_io.box_content;
               state_d = S_OPEN;
            end else begin
               // Failure: a corrupt slip or the open budget is used up.
               fail_count_d = fail_count_q + 1'b1;
               if (fail_count_q == '0) begin
                  fail_prisoner_d = p_q;
               end
`ifdef PRISON_EARLY_ABORT_EN
               win_d   = 1'b0;
               state_d = S_DONE;
`else
               if (p_last) begin
                  win_d   = 1'b0;
                  state_d = S_DONE;
               end else begin
                  p_d     = p_q + 1'b1;
                  box_d   = p_q + 1'b1;
                  opens_d = '0;
                  state_d = S_OPEN;
               end
`endif
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         p_q             <= '0;
         box_q           <= '0;
         opens_q         <= '0;
         win_q           <= 1'b0;
         fail_prisoner_q <= '0;
         fail_count_q    <= '0;
         total_opens_q   <= '0;
      end else begin
         state_q         <= state_d;
         p_q             <= p_d;
         box_q           <= box_d;
         opens_q         <= opens_d;
         win_q           <= win_d;
         fail_prisoner_q <= fail_prisoner_d;
         fail_count_q    <= fail_count_d;
         total_opens_q   <= total_opens_d;
      end
   end

   // Strobes decode straight from the state flop so an async reset drops them at once.
   assign game_io.box_rd        = (state_q == S_OPEN);
   assign game_io.box_sel       = (state_q == S_OPEN) ? box_q : '0;
   assign game_io.busy          = (state_q != S_IDLE);
   assign game_io.done          = (state_q == S_DONE);
   assign game_io.win           = win_q;
   assign game_io.fail_prisoner = fail_prisoner_q;
   assign game_io.fail_count    = fail_count_q;
   assign game_io.total_opens   = total_opens_q;

endmodule

// File: tb/tb_prison_game_controller.sv
// Self-checking bench for prison_game_controller: directed and random box
// layouts compared against a strategy-level model of the game.
module tb_prison_game_controller;

   localparam int N         = 8;
   localparam int IDX_W     = 3;
   localparam int MAX_OPENS = 4;
   localparam int BUDGET    = 400;

   typedef logic [IDX_W-1:0] idx_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   prison_game_if #(.IDX_W(IDX_W)) bus ();

   prison_game_controller #(
      .N_PRISONERS(N),
      .IDX_W      (IDX_W),
      .MAX_OPENS  (MAX_OPENS)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .game_io(bus)
   );

   int   boxes[N];
   int   n_checks = 0;
   int   n_pass   = 0;

   int   exp_t;
   int   exp_fc;
   int   exp_fp;
   logic exp_win;
   int   exp_reads[$];
   int   got_reads[$];

   // Box storage: one-cycle read latency; garbage on the port when not reading.
   always @(posedge clk) begin
      if (bus.box_rd === 1'b1) bus.box_content <= idx_t'(boxes[bus.box_sel]);
      else                     bus.box_content <= idx_t'($urandom);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Strategy model: each prisoner follows slips from their own box, up to MAX_OPENS opens.
   task automatic model();
      exp_t  = 0;
      exp_fc = 0;
      exp_fp = 0;
      exp_reads.delete();
      for (int p = 0; p < N; p++) begin
         int  b;
         bit  found;
         b     = p;
         found = 0;
         for (int k = 0; k < MAX_OPENS; k++) begin
            exp_reads.push_back(b);
            exp_t++;
            if (boxes[b] == p) begin
               found = 1;
               break;
            end
            b = boxes[b];
         end
         if (!found) begin
            if (exp_fc == 0) exp_fp = p;
            exp_fc++;
`ifdef PRISON_EARLY_ABORT_EN
            break;
`endif
         end
      end
      exp_win = (exp_fc == 0);
   endtask

   task automatic run_round(input string name, input int pulse_at);
      int cyc;
      int busy_bad;
      int extra;
      int mism;
      model();
      got_reads.delete();
      busy_bad = 0;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 1;
      while (bus.done !== 1'b1 && cyc < BUDGET) begin
         if (bus.busy !== 1'b1) busy_bad++;
         if (bus.box_rd === 1'b1) got_reads.push_back(int'(bus.box_sel));
         bus.start = (cyc == pulse_at);
         @(negedge clk);
         cyc++;
      end
      bus.start = 1'b0;
      if (bus.busy !== 1'b1) busy_bad++;
      check({name, ".done_cycle"}, cyc, 2 * exp_t + 1);
      check({name, ".busy"}, busy_bad, 0);
      check({name, ".win"}, bus.win, exp_win);
      check({name, ".fail_prisoner"}, bus.fail_prisoner, exp_fp);
      check({name, ".fail_count"}, bus.fail_count, exp_fc);
      check({name, ".total_opens"}, bus.total_opens, exp_t);
      check({name, ".n_reads"}, got_reads.size(), exp_reads.size());
      mism = 0;
      for (int i = 0; i < exp_reads.size(); i++) begin
         if (i >= got_reads.size() || got_reads[i] != exp_reads[i]) mism++;
      end
      check({name, ".read_seq"}, mism, 0);
      extra = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra++;
      end
      check({name, ".idle_after"}, extra, 0);
      check({name, ".win_held"}, bus.win, exp_win);
      check({name, ".fc_held"}, bus.fail_count, exp_fc);
   endtask

   task automatic set_identity();
      for (int i = 0; i < N; i++) boxes[i] = i;
   endtask

   task automatic set_shuffle();
      set_identity();
      for (int i = N - 1; i > 0; i--) begin
         int j;
         int t;
         j        = $urandom_range(i, 0);
         t        = boxes[i];
         boxes[i] = boxes[j];
         boxes[j] = t;
      end
   endtask

   initial begin
      int stray;
      rst       = 1'b1;
      bus.start = 1'b0;
      set_identity();
      repeat (2) @(negedge clk);
      check("rst.box_rd", bus.box_rd, 0);
      check("rst.box_sel", bus.box_sel, 0);
      check("rst.busy", bus.busy, 0);
      check("rst.done", bus.done, 0);
      check("rst.win", bus.win, 0);
      check("rst.fail_prisoner", bus.fail_prisoner, 0);
      check("rst.fail_count", bus.fail_count, 0);
      check("rst.total_opens", bus.total_opens, 0);
      rst = 1'b0;
      @(negedge clk);

      set_identity();
      run_round("identity", 0);

      boxes = '{1, 2, 3, 0, 5, 6, 7, 4};
      run_round("two_4cyc", 0);

      boxes = '{1, 2, 3, 4, 5, 6, 7, 0};
      run_round("one_8cyc", 0);

      boxes = '{1, 2, 3, 0, 5, 6, 7, 4};
      run_round("restart_ignored", 5);

      for (int r = 0; r < 8; r++) begin
         set_shuffle();
         run_round($sformatf("rand%0d", r), (r % 2 == 1) ? int'($urandom_range(20, 2)) : 0);
      end

      // Abort mid-round during an OPEN cycle; outputs must fall without a clock edge.
      set_identity();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (6) @(negedge clk);
      check("abort.pre_box_rd", bus.box_rd, 1);
      #1 rst = 1'b1;
      #1;
      check("abort.box_rd", bus.box_rd, 0);
      check("abort.busy", bus.busy, 0);
      check("abort.win", bus.win, 0);
      check("abort.total_opens", bus.total_opens, 0);
      repeat (2) @(negedge clk);
      rst   = 1'b0;
      stray = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray++;
      end
      check("abort.no_done", stray, 0);

      run_round("post_abort", 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
